// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizers, clock filter, frame FSM with timeout,
// E0/F0 prefix decoding and a show-ahead event FIFO with valid/ready handshake.
module ps2_scancode_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 3,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT     = 50000
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_code,
    output logic                          out_break,
    output logic                          out_ext,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          overflow_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t                 state_r, state_n;
    logic [SYNC_STAGES-1:0] clk_sync_r, data_sync_r;
    logic                   clk_filt_r;
    logic [FW-1:0]          filt_cnt_r;
    logic [TW-1:0]          to_cnt_r;
    logic [2:0]             bit_cnt_r;
    logic [7:0]             shift_r;
    logic                   par_r;
    logic                   frame_ok_r, parity_err_r, frame_err_r;
    logic                   ext_flag_r, brk_flag_r, overflow_r;
    logic [9:0]             mem_r [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_r, rd_ptr_r;
    logic [AW:0]            level_r;
    logic                   sync_clk_s, data_bit_s, edge_s, timeout_s;
    logic                   push_s, pop_s, full_s, wr_en_s;
    logic [9:0]             head_s;

    assign sync_clk_s = clk_sync_r[SYNC_STAGES-1];
    assign data_bit_s = data_sync_r[SYNC_STAGES-1];
    // The filtered clock falls in the cycle the FILTER_LEN-th low sample arrives.
    assign edge_s     = clk_filt_r & ~sync_clk_s & (filt_cnt_r == FW'(FILTER_LEN - 1));
    assign timeout_s  = (state_r != ST_IDLE) & ~edge_s & (to_cnt_r == TW'(TIMEOUT - 1));

    // Input synchronizers, preset to the bus idle level.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_sync_r  <= '1;
            data_sync_r <= '1;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // Clock filter: count consecutive samples that differ from the filtered level.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_filt_r <= 1'b1;
            filt_cnt_r <= '0;
        end else if (sync_clk_s != clk_filt_r) begin
            if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
                clk_filt_r <= sync_clk_s;
                filt_cnt_r <= '0;
            end else begin
                filt_cnt_r <= filt_cnt_r + FW'(1);
            end
        end else begin
            filt_cnt_r <= '0;
        end
    end

    // Inter-edge timeout counter, idle outside a frame.
    always_ff @(posedge clk) begin
        if (!resetn || state_r == ST_IDLE || edge_s) begin
            to_cnt_r <= '0;
        end else if (to_cnt_r != TW'(TIMEOUT)) begin
            to_cnt_r <= to_cnt_r + TW'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Frame FSM next-state logic.
    always_comb begin
        state_n = state_r;
        if (timeout_s) begin
            state_n = ST_IDLE;
        end else if (edge_s) begin
            case (state_r)
                ST_IDLE:   state_n = data_bit_s ? ST_IDLE : ST_DATA;
                ST_DATA:   state_n = (bit_cnt_r == 3'd7) ? ST_PARITY : ST_DATA;
                ST_PARITY: state_n = ST_STOP;
                ST_STOP:   state_n = ST_IDLE;
                default:   state_n = ST_IDLE;
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Frame datapath; the check results are one-cycle pulses after the stop edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'd0;
            par_r        <= 1'b0;
            frame_ok_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            frame_ok_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            if (timeout_s) begin
                frame_err_r <= 1'b1;
            end else if (edge_s) begin
                case (state_r)
                    ST_IDLE: bit_cnt_r <= 3'd0;
                    ST_DATA: begin
                        shift_r   <= {data_bit_s, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                    end
                    ST_PARITY: par_r <= data_bit_s;
                    ST_STOP: begin
                        frame_err_r  <= ~data_bit_s;
                        parity_err_r <= ~(^{shift_r, par_r});
                        frame_ok_r   <= data_bit_s & (^{shift_r, par_r});
                    end
                    default: bit_cnt_r <= 3'd0;
                endcase
            end
        end
    end

    assign push_s  = frame_ok_r & (shift_r != 8'hE0) & (shift_r != 8'hF0);
    assign full_s  = (level_r == (AW+1)'(FIFO_DEPTH));
    assign pop_s   = out_valid & out_ready;
    assign wr_en_s = push_s & (~full_s | pop_s);

    // Prefix flags: set by E0/F0, consumed by any other byte, dropped on errors.
    always_ff @(posedge clk) begin
        if (!resetn || parity_err_r || frame_err_r) begin
            ext_flag_r <= 1'b0;
            brk_flag_r <= 1'b0;
        end else if (frame_ok_r) begin
            ext_flag_r <= (shift_r == 8'hE0) | (ext_flag_r & (shift_r == 8'hF0));
            brk_flag_r <= (shift_r == 8'hF0) | (brk_flag_r & (shift_r == 8'hE0));
        end else begin
            ext_flag_r <= ext_flag_r;
            brk_flag_r <= brk_flag_r;
        end
    end

    // Event FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 10'd0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= {ext_flag_r, brk_flag_r, shift_r};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, pop_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky overflow; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow_r <= 1'b0;
        end else if (push_s & full_s & ~pop_s) begin
            overflow_r <= 1'b1;
        end else if (overflow_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign head_s     = mem_r[rd_ptr_r];
    assign out_valid  = (level_r != '0);
    assign out_code   = head_s[7:0];
    assign out_break  = head_s[8];
    assign out_ext    = head_s[9];
    assign fifo_level = level_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign overflow   = overflow_r;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed self-checking bench for ps2_scancode_rx: PS/2 frames are bit-banged
// on the pins and decoded events are collected by a negedge monitor.
module tb_ps2_scancode_rx;
    localparam int DEPTH = 8;
    localparam int FLEN  = 4;
    localparam int TO    = 1000;
    localparam int H     = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       out_ready = 1'b0;
    logic       overflow_clr = 1'b0;
    logic       out_valid, out_break, out_ext, parity_err, frame_err, overflow;
    logic [7:0] out_code;
    logic [3:0] fifo_level;

    int total = 0;
    int bad = 0;
    int pe_cnt = 0;
    int fe_cnt = 0;
    int vhi_cnt = 0;
    logic [7:0] ev_code [$];
    logic       ev_brk [$];
    logic       ev_ext [$];

    ps2_scancode_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(3), .FILTER_LEN(FLEN), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_break(out_break), .out_ext(out_ext), .fifo_level(fifo_level),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn) begin
            if (out_valid) vhi_cnt++;
            if (out_valid && out_ready) begin
                ev_code.push_back(out_code);
                ev_brk.push_back(out_break);
                ev_ext.push_back(out_ext);
            end
            if (parity_err) pe_cnt++;
            if (frame_err) fe_cnt++;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        ev_code.delete();
        ev_brk.delete();
        ev_ext.delete();
        pe_cnt = 0;
        fe_cnt = 0;
        vhi_cnt = 0;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_cycles(H);
        ps2_clk = 1'b0;
        wait_cycles(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic flip_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(~(^code) ^ flip_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        wait_cycles(3 * H);
    endtask

    task automatic check_one_event(input string name, input logic [7:0] code,
                                   input logic brk, input logic ext);
        total++;
        if (ev_code.size() !== 1) begin
            bad++;
            $display("FAIL %s event_count got=%0d exp=1", name, ev_code.size());
        end else begin
            total++;
            if ({ev_ext[0], ev_brk[0], ev_code[0]} !== {ext, brk, code}) begin
                bad++;
                $display("FAIL %s event got ext=%b brk=%b code=%h exp ext=%b brk=%b code=%h",
                         name, ev_ext[0], ev_brk[0], ev_code[0], ext, brk, code);
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        wait_cycles(4);
        total++;
        if ({out_valid, fifo_level, parity_err, frame_err, overflow} !== 8'd0) begin
            bad++;
            $display("FAIL reset_status got valid=%b level=%0d pe=%b fe=%b ovf=%b exp all 0",
                     out_valid, fifo_level, parity_err, frame_err, overflow);
        end
        total++;
        if ({out_ext, out_break, out_code} !== 10'd0) begin
            bad++;
            $display("FAIL reset_head got ext=%b brk=%b code=%h exp 0", out_ext, out_break, out_code);
        end
        resetn = 1'b1;
        wait_cycles(4);
    endtask

    task automatic test_make();
        out_ready = 1'b1;
        clear_log();
        send_frame(8'h1C, 1'b0);
        check_one_event("make_1c", 8'h1C, 1'b0, 1'b0);
        total++;
        if (vhi_cnt !== 1) begin
            bad++;
            $display("FAIL make_valid_cycles got=%0d exp=1", vhi_cnt);
        end
        total++;
        if (pe_cnt + fe_cnt !== 0) begin
            bad++;
            $display("FAIL make_errors got pe=%0d fe=%0d exp 0", pe_cnt, fe_cnt);
        end
    endtask

    task automatic test_prefix();
        clear_log();
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check_one_event("prefix_e0f075", 8'h75, 1'b1, 1'b1);
        clear_log();
        send_frame(8'h1C, 1'b0);
        check_one_event("prefix_after", 8'h1C, 1'b0, 1'b0);
    endtask

    task automatic test_parity();
        clear_log();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h1C, 1'b1);
        total++;
        if (pe_cnt !== 1 || ev_code.size() !== 0) begin
            bad++;
            $display("FAIL parity_bad got pe=%0d events=%0d exp pe=1 events=0", pe_cnt, ev_code.size());
        end
        clear_log();
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check_one_event("parity_recover", 8'h1C, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        clear_log();
        for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b0);
        total++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1 || out_valid !== 1'b1 || out_code !== 8'h01) begin
            bad++;
            $display("FAIL overflow_full got level=%0d ovf=%b valid=%b head=%h exp 8 1 1 01",
                     fifo_level, overflow, out_valid, out_code);
        end
        out_ready = 1'b1;
        wait_cycles(DEPTH);
        out_ready = 1'b0;
        total++;
        if (fifo_level !== 4'd0 || ev_code.size() !== DEPTH) begin
            bad++;
            $display("FAIL overflow_drain got level=%0d events=%0d exp 0 8", fifo_level, ev_code.size());
        end
        for (int i = 0; i < ev_code.size(); i++) begin
            total++;
            if (ev_code[i] !== 8'(i + 1)) begin
                bad++;
                $display("FAIL overflow_order idx=%0d got=%h exp=%h", i, ev_code[i], 8'(i + 1));
            end
        end
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_sticky got=%b exp=1", overflow);
        end
        overflow_clr = 1'b1;
        wait_cycles(1);
        overflow_clr = 1'b0;
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL overflow_clr got=%b exp=0", overflow);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_timeout();
        clear_log();
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        wait_cycles(TO + 50);
        total++;
        if (fe_cnt !== 1 || ev_code.size() !== 0) begin
            bad++;
            $display("FAIL timeout_pulse got fe=%0d events=%0d exp fe=1 events=0", fe_cnt, ev_code.size());
        end
        clear_log();
        send_frame(8'h1C, 1'b0);
        check_one_event("timeout_recover", 8'h1C, 1'b0, 1'b0);
    endtask

    task automatic test_glitch_and_reset();
        clear_log();
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        wait_cycles(FLEN - 1);
        ps2_clk = 1'b1;
        wait_cycles(2 * H);
        ps2_data = 1'b1;
        send_frame(8'h1C, 1'b0);
        check_one_event("glitch_ignored", 8'h1C, 1'b0, 1'b0);
        total++;
        if (pe_cnt + fe_cnt !== 0) begin
            bad++;
            $display("FAIL glitch_errors got pe=%0d fe=%0d exp 0", pe_cnt, fe_cnt);
        end
        clear_log();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'(i));
        resetn = 1'b0;
        wait_cycles(2);
        resetn = 1'b1;
        ps2_data = 1'b1;
        wait_cycles(2 * H);
        send_frame(8'h1C, 1'b0);
        check_one_event("midframe_reset", 8'h1C, 1'b0, 1'b0);
        total++;
        if (pe_cnt + fe_cnt !== 0) begin
            bad++;
            $display("FAIL midframe_errors got pe=%0d fe=%0d exp 0", pe_cnt, fe_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_make();
        test_prefix();
        test_parity();
        test_overflow();
        test_timeout();
        test_glitch_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

PS/2 keyboard receiver with a parametrised input filter, frame checking, scan-code prefix decoding (E0 extended, F0 break) and a show-ahead output FIFO with a valid/ready handshake. It sits between the PS/2 pins and any consumer that needs decoded key events, such as a key-state table, UART bridge or CPU MMIO. It replaces single-byte receivers that have no flow control, no error reporting and no frame recovery.

## Interface
- FIFO_DEPTH, 8: output FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 3: flops on each input synchronizer; minimum 2.
- FILTER_LEN, 4: consecutive identical synchronized ps2_clk samples required to accept a level change.
- TIMEOUT, 50000: clk cycles allowed between accepted falling edges inside a frame before it is aborted.

- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- ps2_clk  in  1  asynchronous PS/2 clock pin.
- ps2_data  in  1  asynchronous PS/2 data pin.
- out_valid  out  1  FIFO head holds an event.
- out_ready  in  1  consumer accepts the head.
- out_code  out  8  scan code at the FIFO head.
- out_break  out  1  head event is a key release (preceded by F0).
- out_ext  out  1  head event is extended (preceded by E0).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- parity_err  out  1  one-cycle pulse: frame had bad parity.
- frame_err  out  1  one-cycle pulse: bad stop bit or timeout.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- overflow_clr  in  1  clears overflow.

## Operation
- Both pins pass through SYNC_STAGES flops. Filtered ps2_clk changes only after FILTER_LEN equal samples. An accepted edge is a 1→0 transition of the filtered clock. ps2_data is sampled from its synchronizer on that edge.
- Frame FSM states:
  - IDLE → DATA when the accepted edge carries data 0 (start bit); a start bit of 1 is ignored and the FSM stays in IDLE.
  - DATA: 8 edges, LSB first, through a 3-bit bit counter, then → PARITY.
  - PARITY: 1 edge, then → STOP.
  - STOP: 1 edge, then → IDLE.
- Frame checks, evaluated in STOP:
  - Stop bit must be 1, otherwise frame_err.
  - The 8 data bits plus the parity bit must have odd weight, otherwise parity_err.
  - A frame that fails either check is discarded and clears both prefix flags.
- Timeout: a counter resets on every accepted edge and runs in any state other than IDLE. When it reaches TIMEOUT: FSM → IDLE, frame_err pulses, prefix flags clear.
- Prefix decoder, for each valid byte:
  - E0 sets ext_flag.
  - F0 sets brk_flag.
  - Any other byte pushes {ext_flag, brk_flag, byte} into the FIFO and clears both flags.
  - E1 (Pause) is pushed as an ordinary code.
- FIFO:
  - Show-ahead: out_code, out_break and out_ext are valid whenever out_valid is high, and are don't-care otherwise.
  - A pop occurs when out_valid & out_ready.
  - Push while full and no pop: the event is dropped and overflow is set.
  - Push while full with a pop in the same cycle: both are accepted and the level is unchanged.
  - Push and pop together when not full: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow_clr clears overflow; a set event in the same cycle has priority.
- Reset, including mid-frame: FSM → IDLE, bit counter, timeout counter and prefix flags cleared, FIFO emptied, synchronizers and filter loaded with 1 (the bus idle level).

## Timing
- Reset values: out_valid 0, fifo_level 0, parity_err 0, frame_err 0, overflow 0, out_code/out_break/out_ext 0.
- Pin-to-accepted-edge latency: SYNC_STAGES + FILTER_LEN cycles.
- Stop-bit edge at cycle E:
  - Error pulses occur in E+1.
  - FIFO write occurs in E+1.
  - out_valid rises in E+2 if the FIFO was empty.
- A pop at cycle P drops fifo_level in P+1 and presents the next entry in P+1.
- Throughput: one event per frame. Back-to-back pops at full clk rate are supported.
- The timeout pulse is issued in the cycle the counter reaches TIMEOUT.

## Test plan
- Make code 1C (odd parity bit 0, stop 1) with out_ready=1 → one event: code=1C, break=0, ext=0; out_valid high for 1 cycle; no error pulses.
- Frames E0, F0, 75 → single event: code=75, ext=1, break=1; E0 and F0 are never pushed; the next 1C frame has ext=0, break=0.
- Frame 1C with the parity bit inverted → parity_err pulses once, no push. A following F0 then 1C → event with break=1 only, showing the bad frame did not leave a stale prefix.
- out_ready=0, send FIFO_DEPTH+1 codes 01..09 → fifo_level=8, overflow=1, head=01. Draining yields 01..08; code 09 is lost. overflow_clr clears the flag.
- Send start bit plus 3 data bits, then hold ps2_clk high for TIMEOUT cycles → frame_err pulses once. A following 1C frame decodes correctly.
- ps2_clk glitch low for FILTER_LEN-1 cycles → no edge accepted and no state change. Reset asserted mid-frame followed by a clean 1C frame → exactly one event 1C.
